tile_scan_addr_gen: RTL and testbench
=====================================

Name: tile_scan_addr_gen

Overview:
- Parametrised successor to the fixed 4-quadrant window counter.
- Generates (i, j) pixel coordinates that scan an image as a TILES_X x TILES_Y grid of TILE_W x TILE_H tiles, with independent X/Y strides, so tiles may overlap.
- Adds start/done control, a valid/ready output handshake, tile index and last flags, and a loop mode.
- Sits between the frame buffer read port and the conv/pool engine.

Parameters:
- TILE_W, 10, tile width in pixels (i span per tile).
- TILE_H, 8, tile height in pixels (j span per tile).
- STRIDE_X, 8, i offset between horizontally adjacent tile bases.
- STRIDE_Y, 8, j offset between vertically adjacent tile bases.
- TILES_X, 2, number of tiles per tile-row.
- TILES_Y, 2, number of tile-rows.
- COORD_W, 7, width of i/j outputs; must hold (TILES_X-1)*STRIDE_X+TILE_W-1 and the Y equivalent.
- IDX_W, 2, width of tile_idx; must hold TILES_X*TILES_Y-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; 0 freezes all state.
- start  in  1  single-cycle request to begin a frame scan.
- loop  in  1  sampled at start; 1 = restart at tile 0 after the last tile.
- out_valid  out  1  coordinate beat valid.
- out_ready  in  1  consumer accepts the beat.
- i  out  COORD_W  column coordinate.
- j  out  COORD_W  row coordinate.
- tile_idx  out  IDX_W  raster tile number of the current beat.
- last_in_tile  out  1  current beat is the final pixel of its tile.
- last_frame  out  1  current beat is the final pixel of the final tile.
- busy  out  1  state is RUN.
- done  out  1  one-cycle pulse when a non-loop scan completes.

Behaviour:
- Reset (async, any time including mid-scan):
  - state = IDLE; i = j = 0; tile_idx = 0; tile bases = 0.
  - out_valid = busy = done = 0; loop latch = 0.
- State IDLE:
  - out_valid = 0.
  - start & en -> RUN next cycle, with i = j = 0, tile_idx = 0, out_valid = 1, loop latched.
- State RUN: beat accepted when out_valid & out_ready & en. On an accepted beat:
  - Inner: i increments until i == bx + TILE_W - 1, then wraps to bx and j increments.
  - Tile end: when j == by + TILE_H - 1 as well, move to the next tile base.
  - Tile order: bx advances by STRIDE_X across a tile-row; after TILES_X tiles, bx = 0 and by advances by STRIDE_Y.
  - Next beat starts at (bx, by); tile_idx increments.
  - After the last tile with loop latch = 1: bases, i, j and tile_idx return to 0; stay in RUN; no done.
  - After the last tile with loop latch = 0: -> IDLE, out_valid = 0, done = 1 for exactly one cycle.
- Holds and freezes:
  - out_ready = 0: i, j, tile_idx and flags held stable; out_valid stays 1 (no retraction).
  - en = 0: every register frozen, including done (a pending pulse extends), in any state.
  - start while RUN: ignored.
- Flags:
  - last_in_tile and last_frame are combinational from the current registers, gated by out_valid.
- Arithmetic:
  - Base registers are updated by adders only; no multipliers.
  - All counters are unsigned; no wrap beyond the computed end values.
- Throughput and latency:
  - 1 beat/cycle with out_ready held high.
  - Start-to-first-valid latency is 1 cycle.
- Totals at default parameters:
  - 80 beats per tile, 320 per frame.
  - Coordinates span i 0..17, j 0..15.
  - Tiles overlap by 2 columns; rows do not overlap.

Optional Feature:
- Macro: TILE_SERPENTINE_EN.
- Defined: odd tile-rows are traversed right-to-left in bx.
  - Default order becomes bases (0,0), (8,0), (8,8), (0,8).
  - tile_idx still counts 0..3 in visit order.
  - Intra-tile pixel order is unchanged.
- Undefined: plain raster tile order (0,0), (8,0), (0,8), (8,8).

Test Plan:
- Reset and start: assert rst mid-stream at beat 100, then release -> i = j = 0, out_valid = busy = 0; a following start restarts at (0,0) with tile_idx = 0.
- Full frame, defaults, out_ready = 1, loop = 0:
  - beat 0 = (0,0); beat 10 = (0,1).
  - beat 79 = (9,7) with last_in_tile = 1.
  - beat 80 = (8,0) with tile_idx = 1; beat 160 = (0,8) with tile_idx = 2.
  - beat 319 = (17,15) with last_frame = 1.
  - Next cycle: out_valid = 0, done = 1 for one cycle.
- Backpressure: out_ready = 0 for 3 cycles at beat (5,2) -> outputs held at (5,2) with out_valid = 1; after release the next beat is (6,2).
- Enable freeze: en = 0 for 4 cycles at (12,3), tile 1 -> all outputs constant; on resume the next beat is (13,3).
- Loop mode, loop = 1 at start -> after (17,15) the next beat is (0,0) with tile_idx = 0; done never pulses; busy stays 1.
- Serpentine build with TILE_SERPENTINE_EN -> beat 160 = (8,8) with tile_idx = 2; beat 240 = (0,8) with tile_idx = 3; beat 319 = (9,15) with last_frame = 1.

Source files
------------

// File: rtl/tile_scan_addr_gen.sv
// Tiled (i, j) coordinate scanner with valid/ready output and optional loop mode.
// Define TILE_SERPENTINE_EN to walk odd tile-rows right-to-left.
module tile_scan_addr_gen #(
    parameter int TILE_W   = 10,
    parameter int TILE_H   = 8,
    parameter int STRIDE_X = 8,
    parameter int STRIDE_Y = 8,
    parameter int TILES_X  = 2,
    parameter int TILES_Y  = 2,
    parameter int COORD_W  = 7,
    parameter int IDX_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic               loop,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] i,
    output logic [COORD_W-1:0] j,
    output logic [IDX_W-1:0]   tile_idx,
    output logic               last_in_tile,
    output logic               last_frame,
    output logic               busy,
    output logic               done
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam int TXW = (TILES_X > 1) ? $clog2(TILES_X) : 1;
    localparam int TYW = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;

    localparam logic [COORD_W-1:0] W_M1    = COORD_W'(TILE_W - 1);
    localparam logic [COORD_W-1:0] H_M1    = COORD_W'(TILE_H - 1);
    localparam logic [COORD_W-1:0] SX      = COORD_W'(STRIDE_X);
    localparam logic [COORD_W-1:0] SY      = COORD_W'(STRIDE_Y);
    localparam logic [TXW-1:0]     TX_LAST = TXW'(TILES_X - 1);
    localparam logic [TYW-1:0]     TY_LAST = TYW'(TILES_Y - 1);

    logic               state;
    logic               loop_q;
    logic [COORD_W-1:0] bx;
    logic [COORD_W-1:0] by;
    logic [TXW-1:0]     tx;
    logic [TYW-1:0]     ty;
`ifdef TILE_SERPENTINE_EN
    logic               row_rev;
`endif

    logic               row_end;
    logic               tile_end;
    logic               tile_row_last;
    logic               frame_end;
    logic [COORD_W-1:0] nbx;
    logic [COORD_W-1:0] nby;
    logic [TXW-1:0]     ntx;
    logic [TYW-1:0]     nty;

    assign busy          = (state == ST_RUN);
    assign out_valid     = busy;
    assign row_end       = (i == bx + W_M1);
    assign tile_end      = row_end && (j == by + H_M1);
    assign tile_row_last = (tx == TX_LAST);
    assign frame_end     = tile_end && tile_row_last && (ty == TY_LAST);
    assign last_in_tile  = out_valid && tile_end;
    assign last_frame    = out_valid && frame_end;

    // Base of the next tile; tx/ty count tiles in visit order, not in bx/by terms.
    always_comb begin
        nbx = bx;
        nby = by;
        ntx = tx;
        nty = ty;
        if (tile_row_last) begin
            ntx = '0;
            nty = ty + 1'b1;
            nby = by + SY;
`ifdef TILE_SERPENTINE_EN
            nbx = bx;
`else
            nbx = '0;
`endif
        end else begin
            ntx = tx + 1'b1;
`ifdef TILE_SERPENTINE_EN
            nbx = row_rev ? (bx - SX) : (bx + SX);
`else
            nbx = bx + SX;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            loop_q   <= 1'b0;
            done     <= 1'b0;
            i        <= '0;
            j        <= '0;
            bx       <= '0;
            by       <= '0;
            tx       <= '0;
            ty       <= '0;
            tile_idx <= '0;
`ifdef TILE_SERPENTINE_EN
            row_rev  <= 1'b0;
`endif
        end else if (en) begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        loop_q   <= loop;
                        i        <= '0;
                        j        <= '0;
                        bx       <= '0;
                        by       <= '0;
                        tx       <= '0;
                        ty       <= '0;
                        tile_idx <= '0;
`ifdef TILE_SERPENTINE_EN
                        row_rev  <= 1'b0;
`endif
                    end
                end
                default: begin
                    if (out_ready) begin
                        if (frame_end) begin
                            // Either wrap to tile 0 or retire the scan with a done pulse.
                            if (!loop_q) begin
                                state <= ST_IDLE;
                                done  <= 1'b1;
                            end
                            i        <= '0;
                            j        <= '0;
                            bx       <= '0;
                            by       <= '0;
                            tx       <= '0;
                            ty       <= '0;
                            tile_idx <= '0;
`ifdef TILE_SERPENTINE_EN
                            row_rev  <= 1'b0;
`endif
                        end else if (tile_end) begin
                            bx       <= nbx;
                            by       <= nby;
                            tx       <= ntx;
                            ty       <= nty;
                            i        <= nbx;
                            j        <= nby;
                            tile_idx <= tile_idx + 1'b1;
`ifdef TILE_SERPENTINE_EN
                            if (tile_row_last) row_rev <= ~row_rev;
`endif
                        end else if (row_end) begin
                            i <= bx;
                            j <= j + 1'b1;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_scan_addr_gen.sv
// Directed bench for tile_scan_addr_gen at default parameters.
// Checks serpentine tile order instead of raster when TILE_SERPENTINE_EN is defined.
module tb_tile_scan_addr_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       start;
    logic       loop;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] i;
    logic [6:0] j;
    logic [1:0] tile_idx;
    logic       last_in_tile;
    logic       last_frame;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int beat;
        int ei;
        int ej;
        int et;
        int elt;
        int elf;
    } vec_t;

    vec_t vecs[7];

    tile_scan_addr_gen dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .loop(loop),
        .out_valid(out_valid), .out_ready(out_ready), .i(i), .j(j),
        .tile_idx(tile_idx), .last_in_tile(last_in_tile), .last_frame(last_frame),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s_en, input logic s_start,
                                 input logic s_loop, input logic s_ready);
        en        = s_en;
        start     = s_start;
        loop      = s_loop;
        out_ready = s_ready;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Tile base from visit index, written independently of the DUT's adders.
    function automatic void tile_base(input int t, output int bxo, output int byo);
        int r;
        int c;
        r = t / 2;
        c = t % 2;
`ifdef TILE_SERPENTINE_EN
        if (r % 2 == 1) c = 1 - c;
`endif
        bxo = c * 8;
        byo = r * 8;
    endfunction

    function automatic logic [31:0] pack(input int pi, input int pj, input int pt,
                                         input int plt, input int plf, input int pv, input int pd);
        logic [31:0] r;
        r = {8'd0, pi[6:0], pj[6:0], pt[1:0], plt[0], plf[0], pv[0], pd[0], 4'd0};
        return r;
    endfunction

    function automatic logic [31:0] dut_pack();
        return pack(int'(i), int'(j), int'(tile_idx), int'(last_in_tile),
                    int'(last_frame), int'(out_valid), int'(done));
    endfunction

    function automatic logic [31:0] model_pack(input int b);
        int t;
        int p;
        int bxo;
        int byo;
        t = b / 80;
        p = b % 80;
        tile_base(t, bxo, byo);
        return pack(bxo + p % 10, byo + p / 10, t, (p == 79) ? 1 : 0, (b == 319) ? 1 : 0, 1, 0);
    endfunction

    // Checks beat b against the model and any table entry, then lets it be accepted.
    task automatic checkBeat(input int b);
        checkOutput($sformatf("beat%0d", b), dut_pack(), model_pack(b));
        for (int k = 0; k < 7; k++) begin
            if (vecs[k].beat == b) begin
                checkOutput($sformatf("vec%0d_i", k), 32'(i), 32'(vecs[k].ei));
                checkOutput($sformatf("vec%0d_j", k), 32'(j), 32'(vecs[k].ej));
                checkOutput($sformatf("vec%0d_tile", k), 32'(tile_idx), 32'(vecs[k].et));
                checkOutput($sformatf("vec%0d_lit", k), 32'(last_in_tile), 32'(vecs[k].elt));
                checkOutput($sformatf("vec%0d_lf", k), 32'(last_frame), 32'(vecs[k].elf));
            end
        end
    endtask

    task automatic startScan(input logic l);
        applyStimulus(1'b1, 1'b1, l, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        vecs[0] = '{0,   0,  0,  0, 0, 0};
        vecs[1] = '{10,  0,  1,  0, 0, 0};
        vecs[2] = '{79,  9,  7,  0, 1, 0};
        vecs[3] = '{80,  8,  0,  1, 0, 0};
`ifdef TILE_SERPENTINE_EN
        vecs[4] = '{160, 8,  8,  2, 0, 0};
        vecs[5] = '{240, 0,  8,  3, 0, 0};
        vecs[6] = '{319, 9,  15, 3, 1, 1};
`else
        vecs[4] = '{160, 0,  8,  2, 0, 0};
        vecs[5] = '{240, 8,  8,  3, 0, 0};
        vecs[6] = '{319, 17, 15, 3, 1, 1};
`endif

        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("reset_state", dut_pack(), pack(0, 0, 0, 0, 0, 0, 0));
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("idle_no_start", 32'(out_valid), 32'd0);

        $display("[TB] full frame");
        startScan(1'b0);
        checkOutput("start_busy", 32'(busy), 32'd1);
        for (int b = 0; b < 320; b++) begin
            checkBeat(b);
            tick();
        end
        checkOutput("end_valid", 32'(out_valid), 32'd0);
        checkOutput("end_done", 32'(done), 32'd1);
        tick();
        checkOutput("done_one_cycle", 32'(done), 32'd0);

        $display("[TB] backpressure and enable freeze");
        startScan(1'b0);
        for (int b = 0; b < 25; b++) tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("bp_hold%0d", c), dut_pack(), model_pack(25));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("bp_next", dut_pack(), model_pack(26));
        checkOutput("bp_next_i", 32'(i), 32'd6);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("start_ignored", dut_pack(), model_pack(27));
        for (int b = 27; b < 114; b++) tick();
        checkOutput("frz_pos", dut_pack(), pack(12, 3, 1, 0, 0, 1, 0));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput($sformatf("en_hold%0d", c), dut_pack(), pack(12, 3, 1, 0, 0, 1, 0));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("en_resume", dut_pack(), pack(13, 3, 1, 0, 0, 1, 0));
        for (int b = 115; b < 319; b++) tick();
        checkBeat(319);
        tick();
        checkOutput("done_pulse2", 32'(done), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("done_frozen", 32'(done), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("done_released", 32'(done), 32'd0);

        $display("[TB] loop mode");
        startScan(1'b1);
        for (int b = 0; b < 320; b++) begin
            checkBeat(b);
            tick();
        end
        checkOutput("loop_wrap", dut_pack(), model_pack(0));
        checkOutput("loop_busy", 32'(busy), 32'd1);
        for (int b = 1; b < 100; b++) tick();

        $display("[TB] async reset mid-stream");
        checkOutput("pre_reset_beat", dut_pack(), model_pack(99));
        tick();
        rst = 1'b1;
        #1;
        checkOutput("async_reset", dut_pack(), pack(0, 0, 0, 0, 0, 0, 0));
        checkOutput("async_reset_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("post_reset_idle", 32'(out_valid), 32'd0);
        startScan(1'b0);
        checkOutput("restart", dut_pack(), model_pack(0));
        tick();
        checkOutput("restart_b1", dut_pack(), model_pack(1));

        $display("[TB] test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
